// File: rtl/ram_sdp_param_if.sv
// Bus bundle for ram_sdp_param: write port, read request/response, status flags
// and the controller state for observation.
interface ram_sdp_param_if #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 8
);
  logic              write_en;
  logic [ADDR_W-1:0] write_addr;
  logic [DATA_W-1:0] write_data;
  logic              read_en;
  logic [ADDR_W-1:0] read_addr;
  logic [DATA_W-1:0] read_data;
  logic              read_valid;
  logic              addr_err;
  logic              init_done;
  logic              state_dbg;

  // Handshake: requests are plain strobes sampled on every rising edge while
  // init_done is high; there is no back-pressure. read_valid is a single-cycle
  // qualifier for read_data, one result per accepted read_en, in request order.
  modport master (
    output write_en, write_addr, write_data, read_en, read_addr,
    input  read_data, read_valid, addr_err, init_done, state_dbg
  );

  modport slave (
    input  write_en, write_addr, write_data, read_en, read_addr,
    output read_data, read_valid, addr_err, init_done, state_dbg
  );
endinterface

// File: rtl/ram_sdp_param.sv
// Simple dual-port synchronous RAM with post-reset clear, configurable
// read-during-write behaviour, optional output register and range checking.
module ram_sdp_param #(
  parameter int DATA_W   = 4,
  parameter int ADDR_W   = 8,
  parameter int DEPTH    = 128,
  parameter int RDW_MODE = 0,
  parameter int OUT_REG  = 0
) (
  input  logic              clk,
  input  logic              rst,
  ram_sdp_param_if.slave    bus
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_READY = 1'b1
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_clr_cnt;
  logic              r_init_done;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic [DATA_W-1:0] r_rd_data1;
  logic              r_rd_valid1;
  logic [DATA_W-1:0] r_rd_data2;
  logic              r_rd_valid2;
  logic              r_addr_err;

  logic              w_ready;
  logic              w_wr_in;
  logic              w_rd_in;
  logic              w_wr_ok;
  logic              w_rd_ok;
  logic              w_collide;
  logic              w_mem_we;
  logic [IDX_W-1:0]  w_mem_waddr;
  logic [DATA_W-1:0] w_mem_wdata;
  logic [DATA_W-1:0] w_rd_word;

  // Range checks use the full address width so out-of-range never aliases.
  assign w_wr_in   = 32'(bus.write_addr) < DEPTH;
  assign w_rd_in   = 32'(bus.read_addr) < DEPTH;
  assign w_ready   = (r_state == S_READY) && !rst;
  assign w_wr_ok   = w_ready && bus.write_en && w_wr_in;
  assign w_rd_ok   = w_ready && bus.read_en;
  assign w_collide = w_wr_ok && bus.read_en && (bus.read_addr == bus.write_addr);

  // The clear sequence owns the single write port until it completes.
  always_comb begin
    w_mem_we    = 1'b0;
    w_mem_waddr = '0;
    w_mem_wdata = '0;
    if (!rst && (r_state == S_CLEAR)) begin
      w_mem_we    = 1'b1;
      w_mem_waddr = r_clr_cnt[IDX_W-1:0];
    end else if (w_wr_ok) begin
      w_mem_we    = 1'b1;
      w_mem_waddr = bus.write_addr[IDX_W-1:0];
      w_mem_wdata = bus.write_data;
    end
  end

  always_comb begin
    w_rd_word = '0;
    if (w_rd_in) begin
      if (w_collide && (RDW_MODE == 0)) begin
        w_rd_word = bus.write_data;
      end else begin
        w_rd_word = r_mem[bus.read_addr[IDX_W-1:0]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_waddr] <= w_mem_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_CLEAR;
      r_clr_cnt   <= '0;
      r_init_done <= 1'b0;
    end else begin
      case (r_state)
        S_CLEAR: begin
          r_clr_cnt <= r_clr_cnt + 1'b1;
          if (r_clr_cnt == LAST_ADDR) begin
            r_state     <= S_READY;
            r_init_done <= 1'b1;
            r_clr_cnt   <= '0;
          end
        end
        S_READY: begin
          r_state <= S_READY;
        end
        default: begin
          r_state <= S_CLEAR;
        end
      endcase
    end
  end

  // Stage 1 registers the array read; stage 2 is the optional output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_data1  <= '0;
      r_rd_valid1 <= 1'b0;
      r_rd_data2  <= '0;
      r_rd_valid2 <= 1'b0;
      r_addr_err  <= 1'b0;
    end else begin
      r_rd_valid1 <= w_rd_ok;
      if (w_rd_ok) begin
        r_rd_data1 <= w_rd_word;
      end
      r_addr_err  <= w_ready && ((bus.write_en && !w_wr_in) ||
                                 (bus.read_en && !w_rd_in));
      r_rd_valid2 <= r_rd_valid1;
      if (r_rd_valid1) begin
        r_rd_data2 <= r_rd_data1;
      end
    end
  end

  assign bus.read_data  = (OUT_REG != 0) ? r_rd_data2 : r_rd_data1;
  assign bus.read_valid = (OUT_REG != 0) ? r_rd_valid2 : r_rd_valid1;
  assign bus.addr_err   = r_addr_err;
  assign bus.init_done  = r_init_done;
  assign bus.state_dbg  = r_state;
endmodule
